// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - RV32I decode stage: register file, ID/EX register, load-use stall
module decode_pipe #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int CTRL_W = 12,
  parameter int A0_IDX = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic              ValidD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   inc_PCD,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic              UsesRs1D,
  input  logic              UsesRs2D,
  input  logic              IsLoadD,
  input  logic              RegWriteW,
  input  logic [AW-1:0]     RdW,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              HoldE,
  input  logic              FlushE,
  output logic              StallFD,
  output logic              ValidE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic              IsLoadE,
  output logic [XLEN-1:0]   rs1E,
  output logic [XLEN-1:0]   rs2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   inc_PCE,
  output logic [2:0]        funct3E,
  output logic [AW-1:0]     RdE,
  output logic [XLEN-1:0]   a0
);

  logic [XLEN-1:0] regs [NREG];
  logic [AW-1:0]   rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] rs1D, rs2D;
  logic            lu;
  logic            unused_instr;

  assign rs1_idx = InstrD[15 +: AW];
  assign rs2_idx = InstrD[20 +: AW];
  assign rd_idx  = InstrD[7 +: AW];

  // opcode and funct7 are decoded by the CU, not here
  assign unused_instr = ^InstrD;

  // register file: writes to x0 are dropped so x0 stays zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (RegWriteW && (RdW != '0)) begin
      regs[RdW] <= ResultW;
    end
  end

  // operand read with write-first bypass from writeback
  always_comb begin
    rs1D = '0;
    rs2D = '0;
    if (rs1_idx != '0) begin
      if (RegWriteW && (RdW == rs1_idx)) rs1D = ResultW;
      else                               rs1D = regs[rs1_idx];
    end
    if (rs2_idx != '0) begin
      if (RegWriteW && (RdW == rs2_idx)) rs2D = ResultW;
      else                               rs2D = regs[rs2_idx];
    end
  end

  assign a0 = regs[A0_IDX];

  // load in E feeding a source of the instruction in D
  assign lu = ValidD & ValidE & IsLoadE & (RdE != '0) &
              ((UsesRs1D & (rs1_idx == RdE)) | (UsesRs2D & (rs2_idx == RdE)));

  // a flush discards D anyway, so a hazard against it needs no stall
  assign StallFD = HoldE | (lu & ~FlushE);

  // ID/EX register: hold beats flush, flush and load-use both insert a bubble
  always_ff @(posedge clk) begin
    if (rst || (!HoldE && (FlushE || lu))) begin
      ValidE  <= 1'b0;
      CtrlE   <= '0;
      IsLoadE <= 1'b0;
      RdE     <= '0;
      rs1E    <= '0;
      rs2E    <= '0;
      ImmExtE <= '0;
      PCE     <= '0;
      inc_PCE <= '0;
      funct3E <= '0;
    end else if (!HoldE) begin
      ValidE  <= ValidD;
      CtrlE   <= ValidD ? CtrlD : '0;
      IsLoadE <= ValidD & IsLoadD;
      RdE     <= ValidD ? rd_idx : '0;
      rs1E    <= rs1D;
      rs2E    <= rs2D;
      ImmExtE <= ImmExtD;
      PCE     <= PCD;
      inc_PCE <= inc_PCD;
      funct3E <= InstrD[14:12];
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// tb/tb_decode_pipe.sv - directed self-checking bench for decode_pipe
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD;
  logic        ValidD;
  logic [31:0] PCD, inc_PCD;
  logic [11:0] CtrlD;
  logic [31:0] ImmExtD;
  logic        UsesRs1D, UsesRs2D, IsLoadD;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        HoldE, FlushE;
  logic        StallFD, ValidE, IsLoadE;
  logic [11:0] CtrlE;
  logic [31:0] rs1E, rs2E, ImmExtE, PCE, inc_PCE, a0;
  logic [2:0]  funct3E;
  logic [4:0]  RdE;

  int checks = 0;
  int errors = 0;

  decode_pipe dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD), .PCD(PCD), .inc_PCD(inc_PCD),
    .CtrlD(CtrlD), .ImmExtD(ImmExtD), .UsesRs1D(UsesRs1D), .UsesRs2D(UsesRs2D),
    .IsLoadD(IsLoadD), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .HoldE(HoldE), .FlushE(FlushE), .StallFD(StallFD), .ValidE(ValidE), .CtrlE(CtrlE),
    .IsLoadE(IsLoadE), .rs1E(rs1E), .rs2E(rs2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .inc_PCE(inc_PCE), .funct3E(funct3E), .RdE(RdE), .a0(a0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd, input logic [2:0] f3);
    return {7'h00, rs2, rs1, f3, rd, 7'h33};
  endfunction

  task automatic idle();
    InstrD = 32'h0; ValidD = 1'b0; PCD = 32'h0; inc_PCD = 32'h0; CtrlD = 12'h0;
    ImmExtD = 32'h0; UsesRs1D = 1'b0; UsesRs2D = 1'b0; IsLoadD = 1'b0;
    RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'h0; HoldE = 1'b0; FlushE = 1'b0;
  endtask

  task automatic present(input logic [31:0] instr, input logic [11:0] ctrl,
                         input logic u1, input logic u2, input logic ld);
    InstrD = instr; ValidD = 1'b1; CtrlD = ctrl;
    UsesRs1D = u1; UsesRs2D = u2; IsLoadD = ld;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    // reset with random inputs, reset must override everything
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      InstrD = $urandom; ValidD = 1'b1; CtrlD = 12'($urandom); ImmExtD = $urandom;
      PCD = $urandom; inc_PCD = $urandom; RegWriteW = 1'b1; RdW = 5'd10;
      ResultW = $urandom; IsLoadD = 1'b1; UsesRs1D = 1'b1; UsesRs2D = 1'b1;
    end
    tick();
    rst = 1'b0;
    idle();
    check("rst_valid", {31'b0, ValidE}, 32'h0);
    check("rst_ctrl", {20'b0, CtrlE}, 32'h0);
    check("rst_rd", {27'b0, RdE}, 32'h0);
    check("rst_rs1", rs1E, 32'h0);
    check("rst_imm", ImmExtE, 32'h0);
    check("rst_a0", a0, 32'h0);

    // read x5 after reset
    present(mk(5'd5, 5'd0, 5'd1, 3'd0), 12'h001, 1'b1, 1'b0, 1'b0);
    tick();
    check("x5_after_rst", rs1E, 32'h0);

    // write x5 and bypass it in the same cycle
    present(mk(5'd5, 5'd0, 5'd6, 3'd5), 12'hA5C, 1'b1, 1'b0, 1'b0);
    PCD = 32'h0000_0100; inc_PCD = 32'h0000_0104; ImmExtD = 32'hFFFF_FFF0;
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEAD_BEEF;
    tick();
    check("bypass_rs1", rs1E, 32'hDEAD_BEEF);
    check("cap_valid", {31'b0, ValidE}, 32'h1);
    check("cap_ctrl", {20'b0, CtrlE}, 32'h0000_0A5C);
    check("cap_rd", {27'b0, RdE}, 32'd6);
    check("cap_f3", {29'b0, funct3E}, 32'd5);
    check("cap_pc", PCE, 32'h0000_0100);
    check("cap_incpc", inc_PCE, 32'h0000_0104);
    check("cap_imm", ImmExtE, 32'hFFFF_FFF0);

    // x5 now from the array through rs2
    RegWriteW = 1'b0;
    present(mk(5'd0, 5'd5, 5'd6, 3'd0), 12'h002, 1'b0, 1'b1, 1'b0);
    tick();
    check("rf_rs2", rs2E, 32'hDEAD_BEEF);

    // x0 write is dropped, and never bypassed
    present(mk(5'd0, 5'd0, 5'd1, 3'd0), 12'h003, 1'b1, 1'b1, 1'b0);
    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h0000_1234;
    tick();
    check("x0_bypass", rs1E, 32'h0);
    RegWriteW = 1'b0;
    tick();
    check("x0_read", rs1E, 32'h0);

    // a0 export, no bypass before the edge
    RegWriteW = 1'b1; RdW = 5'd10; ResultW = 32'h0000_002A;
    #1;
    check("a0_pre_edge", a0, 32'h0);
    tick();
    RegWriteW = 1'b0;
    check("a0_post_edge", a0, 32'h0000_002A);

    // load-use: load x7 into E, then add reading x7 via rs2
    present(mk(5'd2, 5'd0, 5'd7, 3'd2), 12'h111, 1'b1, 1'b0, 1'b1);
    tick();
    check("ld_isload", {31'b0, IsLoadE}, 32'h1);
    present(mk(5'd3, 5'd7, 5'd8, 3'd0), 12'h222, 1'b1, 1'b1, 1'b0);
    RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'h0000_0077;
    #1;
    check("lu_stall", {31'b0, StallFD}, 32'h1);
    tick();
    RegWriteW = 1'b0;
    check("bubble_valid", {31'b0, ValidE}, 32'h0);
    check("bubble_ctrl", {20'b0, CtrlE}, 32'h0);
    check("bubble_rd", {27'b0, RdE}, 32'h0);
    #1;
    check("lu_released", {31'b0, StallFD}, 32'h0);
    tick();
    check("add_valid", {31'b0, ValidE}, 32'h1);
    check("add_rd", {27'b0, RdE}, 32'd8);
    check("add_ctrl", {20'b0, CtrlE}, 32'h0000_0222);
    check("write_during_bubble", rs2E, 32'h0000_0077);

    // same shape but rs2 not used: no stall
    present(mk(5'd2, 5'd0, 5'd7, 3'd2), 12'h111, 1'b1, 1'b0, 1'b1);
    tick();
    present(mk(5'd3, 5'd7, 5'd8, 3'd0), 12'h222, 1'b1, 1'b0, 1'b0);
    #1;
    check("no_use_nostall", {31'b0, StallFD}, 32'h0);
    tick();
    check("no_use_valid", {31'b0, ValidE}, 32'h1);

    // flush squashes a valid D
    present(mk(5'd1, 5'd2, 5'd9, 3'd0), 12'h0F0, 1'b1, 1'b1, 1'b0);
    FlushE = 1'b1;
    tick();
    check("flush_valid", {31'b0, ValidE}, 32'h0);
    check("flush_rd", {27'b0, RdE}, 32'h0);

    // flush with a load-use hazard does not stall
    FlushE = 1'b0;
    present(mk(5'd2, 5'd0, 5'd7, 3'd2), 12'h111, 1'b1, 1'b0, 1'b1);
    tick();
    present(mk(5'd7, 5'd0, 5'd8, 3'd0), 12'h222, 1'b1, 1'b0, 1'b0);
    FlushE = 1'b1;
    #1;
    check("flush_lu_nostall", {31'b0, StallFD}, 32'h0);
    tick();
    check("flush_lu_valid", {31'b0, ValidE}, 32'h0);

    // hold beats flush
    FlushE = 1'b0;
    present(mk(5'd0, 5'd0, 5'd12, 3'd0), 12'h3C3, 1'b1, 1'b0, 1'b0);
    tick();
    HoldE = 1'b1; FlushE = 1'b1;
    present(mk(5'd1, 5'd1, 5'd13, 3'd1), 12'h555, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_stall", {31'b0, StallFD}, 32'h1);
      tick();
      check("hold_valid", {31'b0, ValidE}, 32'h1);
      check("hold_rd", {27'b0, RdE}, 32'd12);
      check("hold_ctrl", {20'b0, CtrlE}, 32'h0000_03C3);
    end
    HoldE = 1'b0;
    tick();
    check("unhold_flush_valid", {31'b0, ValidE}, 32'h0);
    check("unhold_flush_ctrl", {20'b0, CtrlE}, 32'h0);

    // invalid D: control cleared, data still captured
    FlushE = 1'b0;
    present(mk(5'd0, 5'd0, 5'd14, 3'd3), 12'h777, 1'b0, 1'b0, 1'b1);
    ValidD = 1'b0; ImmExtD = 32'h1357_9BDF;
    tick();
    check("inv_valid", {31'b0, ValidE}, 32'h0);
    check("inv_ctrl", {20'b0, CtrlE}, 32'h0);
    check("inv_isload", {31'b0, IsLoadE}, 32'h0);
    check("inv_imm", ImmExtE, 32'h1357_9BDF);

    // reset clears the register file too
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rerst_a0", a0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised decode stage for the pipelined RV32I core.
- Contains:
  - NREG x XLEN register file with write-first bypass from writeback.
  - ID/EX pipeline register with valid bit, hold, flush and bubble insertion.
  - Load-use hazard detector that stalls Fetch/Decode.
- Control-word decoding stays in the external CU. Control is carried as an opaque CTRL_W-bit bundle, so this block can be reused when the control set grows.

Parameters:
- XLEN, 32: datapath width.
- NREG, 32: number of architectural registers; register 0 is hard-wired to zero.
- AW, $clog2(NREG): register-index width.
- CTRL_W, 12: width of the control bundle from the CU.
- A0_IDX, 10: index of the register exported on a0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- InstrD  in  32  instruction in Decode; Rs1D=InstrD[19:15], Rs2D=InstrD[24:20], RdD=InstrD[11:7] (low AW bits).
- ValidD  in  1  Decode holds a real instruction.
- PCD, inc_PCD  in  XLEN each  PC and PC+4 of the Decode instruction.
- CtrlD  in  CTRL_W  control bundle from CU.
- ImmExtD  in  XLEN  sign-extended immediate.
- UsesRs1D, UsesRs2D  in  1 each  instruction reads rs1 / rs2.
- IsLoadD  in  1  instruction is a load.
- RegWriteW  in  1  writeback enable.
- RdW  in  AW  writeback index.
- ResultW  in  XLEN  writeback data.
- HoldE  in  1  downstream stall; freeze the E register.
- FlushE  in  1  squash the E register (taken branch/jump).
- StallFD  out  1  freeze PC and IF/ID register.
- ValidE  out  1
- CtrlE  out  CTRL_W
- IsLoadE  out  1
- rs1E, rs2E, ImmExtE, PCE, inc_PCE  out  XLEN each
- funct3E  out  3
- RdE  out  AW
- a0  out  XLEN  combinational view of reg[A0_IDX] (no bypass).

Behaviour:
- Reset (rst high at a clk edge): all registers in the register file become 0. All E outputs become 0 (ValidE=0, CtrlE=0, RdE=0, IsLoadE=0, data fields 0). a0=0 after the edge. rst overrides every other input.
- Register file write: at clk, if RegWriteW and RdW!=0, reg[RdW]<=ResultW. Writes to index 0 are ignored. Index 0 always reads 0.
- Register file read: combinational. Write-first bypass: if RegWriteW && RdW==Rs1D && Rs1D!=0, rs1D=ResultW, else reg[Rs1D]. Same rule for rs2.
- Load-use detection (combinational):
  - lu = ValidD & ValidE & IsLoadE & (RdE!=0) & ((UsesRs1D & Rs1D==RdE) | (UsesRs2D & Rs2D==RdE)).
- StallFD = HoldE | (lu & ~FlushE).
- E register update at clk, first matching rule wins:
  1. rst: clear.
  2. HoldE: all E outputs keep their value.
  3. FlushE: clear (bubble).
  4. lu: clear (bubble inserted; the Decode instruction is held by StallFD and re-presented next cycle).
  5. Otherwise: capture D fields. ValidE<=ValidD. CtrlE, IsLoadE and RdE are captured only when ValidD, else cleared. Data fields are always captured.
- Latency: one cycle from D inputs to E outputs. Single-cycle load-use penalty.
- The bubble condition is fully deasserted one cycle after insertion, because ValidE=0 after the bubble.
- HoldE and FlushE together: hold wins. Upstream control must keep FlushE asserted until HoldE drops.
- A register write and a bubble in the same cycle are independent; the write always occurs.

Test Plan:
- Reset then idle: assert rst for 2 cycles with random inputs -> ValidE=0, CtrlE=0, RdE=0, rs1E=0, a0=0; a read of x5 returns 0.
- Write and bypass: RegWriteW=1, RdW=5, ResultW=0xDEADBEEF; same cycle InstrD rs1=5, ValidD=1 -> next cycle rs1E=0xDEADBEEF. Write to x0 with 0x1234 -> later read of x0 gives 0.
- a0 export: write x10=0x0000002A -> a0=0x2A the cycle after the edge.
- Load-use: E holds a load with RdE=7, IsLoadE=1; D has add with rs2=7, UsesRs2D=1 -> StallFD=1; next edge gives ValidE=0, CtrlE=0; following edge captures the add with StallFD=0. Same case with UsesRs2D=0 -> no stall.
- Flush: ValidD=1 with FlushE=1 -> next cycle ValidE=0, RdE=0. FlushE with lu active -> StallFD=0.
- Hold priority: HoldE=1 with FlushE=1 for 3 cycles -> E outputs unchanged and StallFD=1. Drop HoldE with FlushE still 1 -> bubble on the next edge.
